pla_pipe_eval: RTL



---
 rtl/pla_pkg.sv | 22 ++
 rtl/pla_term_match.sv | 21 ++
 rtl/pla_pipe_eval.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pla_pkg.sv
// Shared types and constants for the programmable PLA evaluator.
// Literal encoding per input: {care, pol}; care=0 ignores the input.
package pla_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] LIT_DC  = 2'b00;
    localparam logic [1:0] LIT_NEG = 2'b10;
    localparam logic [1:0] LIT_POS = 2'b11;

    // Index width for a table of n entries (at least one bit).
    function automatic int idx_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/pla_term_match.sv
// Combinational literal match of one product term against the input vector.
// Mask-based enabling is applied by the caller, not here.
module pla_term_match
    import pla_pkg::*;
#(
    parameter int N_IN = 8
) (
    input  logic [2*N_IN-1:0] i_cube,
    input  logic [N_IN-1:0]   i_vec,
    output logic              o_match
);

    always_comb begin
        o_match = 1'b1;
        for (int i = 0; i < N_IN; i++) begin
            if (i_cube[2*i+1] && (i_cube[2*i +: 2] != (i_vec[i] ? LIT_POS : LIT_NEG)))
                o_match = 1'b0;
        end
    end

endmodule

// File: rtl/pla_pipe_eval.sv
// Run-time programmable sum-of-products evaluator: term table, INIT/RUN sweep FSM,
// and a two-stage valid/ready pipeline (hit vector, then OR of matching masks).
module pla_pipe_eval
    import pla_pkg::*;
#(
    parameter int N_IN   = 8,
    parameter int N_OUT  = 16,
    parameter int N_TERM = 32,
    parameter int IDXW   = idx_w(N_TERM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_OUT-1:0]  out_vec,
    output logic              out_hit,
    input  logic              cfg_we,
    input  logic              cfg_clr,
    output logic              cfg_ready,
    input  logic [IDXW-1:0]   cfg_idx,
    input  logic [2*N_IN-1:0] cfg_cube,
    input  logic [N_OUT-1:0]  cfg_mask,
    output state_t            dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // ready may depend on valid-side inputs, valid never depends on ready.
    state_t              r_state;
    logic [IDXW-1:0]     r_cnt;
    logic [2*N_IN-1:0]   r_cube [N_TERM];
    logic [N_OUT-1:0]    r_mask [N_TERM];
    logic                r_s1_valid;
    logic [N_TERM-1:0]   r_s1_hit;
    logic                r_s2_valid;
    logic [N_OUT-1:0]    r_s2_vec;
    logic                r_s2_hit;

    logic [N_TERM-1:0]   w_lit_match;
    logic [N_TERM-1:0]   w_hit;
    logic [N_OUT-1:0]    w_or;
    logic                w_adv;
    logic                w_in_fire;
    logic                w_cfg_write;

    for (genvar g = 0; g < N_TERM; g++) begin : g_term
        pla_term_match #(.N_IN(N_IN)) u_match (
            .i_cube (r_cube[g]),
            .i_vec  (in_vec),
            .o_match(w_lit_match[g])
        );
        assign w_hit[g] = w_lit_match[g] & (|r_mask[g]);
    end

    assign w_adv       = ~r_s2_valid | out_ready;
    assign in_ready    = (r_state == RUN) & ~cfg_we & ~cfg_clr & w_adv;
    assign cfg_ready   = (r_state == RUN) & ~r_s1_valid & ~r_s2_valid;
    assign w_in_fire   = in_valid & in_ready;
    assign w_cfg_write = cfg_we & ~cfg_clr & cfg_ready;

    always_comb begin
        w_or = '0;
        for (int t = 0; t < N_TERM; t++) begin
            if (r_s1_hit[t]) w_or = w_or | r_mask[t];
        end
    end

    // Table storage is not reset; the INIT sweep clears it one term per cycle.
    always_ff @(posedge clk) begin
        if (r_state == INIT) begin
            r_cube[r_cnt] <= '0;
            r_mask[r_cnt] <= '0;
        end else if (w_cfg_write) begin
            r_cube[cfg_idx] <= cfg_cube;
            r_mask[cfg_idx] <= cfg_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == IDXW'(N_TERM - 1)) r_state <= RUN;
                end
                RUN: begin
                    if (cfg_clr & cfg_ready) begin
                        r_state <= INIT;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    // Data registers only load when a valid item moves into them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_hit   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_vec   <= '0;
            r_s2_hit   <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= w_in_fire;
            if (w_in_fire) r_s1_hit <= w_hit;
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_vec <= w_or;
                r_s2_hit <= |r_s1_hit;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_vec   = r_s2_vec;
    assign out_hit   = r_s2_hit;
    assign dbg_state = r_state;

endmodule
